// File: rtl/sevenseg_mux_driver.sv
// Multiplexed N-digit seven-segment driver feeding two chained 74HC595 shift registers.
// Optional PWM brightness control is enabled by defining SEVENSEG_BRIGHTNESS_EN.
module sevenseg_mux_driver #(
   parameter int DIGITS         = 4,
   parameter int SYSCLK_F       = 24000000,
   parameter int SHIFT_CLK_F    = 2000000,
   parameter int DISPLAY_HZ     = 800,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [8*DIGITS-1:0] segs,
`ifdef SEVENSEG_BRIGHTNESS_EN
   input  logic [3:0]          bright,
`endif
   output logic                sclk,
   output logic                rclk,
   output logic                oe_n,
   output logic                dout,
   output logic                frame_start
);
   localparam int DIV  = SYSCLK_F / SHIFT_CLK_F;
   localparam int HALF = DIV / 2;
   localparam int SLOT = SYSCLK_F / (DISPLAY_HZ * DIGITS);
   localparam int SW   = $clog2(SLOT);
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW   = $clog2(DIV + 1);

   if (DIV < 2 || DIGITS < 1 || DIGITS > 8 || SLOT < 16 * DIV + HALF + 2) begin : g_bad_cfg
      $error("sevenseg_mux_driver: invalid DIV/DIGITS/SLOT combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_LO, S_BIT_HI, S_LATCH} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_slot;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_phase;
   logic [3:0]      r_bit;
   logic [14:0]     r_word;
   logic            r_on;
   logic            w_slot_wrap;
   logic [SW-1:0]   w_slot_next;
   logic [IW-1:0]   w_idx_next;
   logic [7:0]      w_digit [DIGITS];
   logic [7:0]      w_sel;
   logic [7:0]      w_seg;
   logic [15:0]     w_word;
   logic            w_on_next;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_digit[gi] = segs[8*gi +: 8];
   end

   assign w_sel       = (8'd1 << r_idx) ^ {8{SEL_ACTIVE_LOW}};
   assign w_seg       = w_digit[r_idx] ^ {8{SEG_ACTIVE_LOW}};
   assign w_word      = {w_sel, w_seg};
   assign w_slot_wrap = (r_slot == SW'(SLOT - 1));
   assign w_slot_next = w_slot_wrap ? '0 : r_slot + 1'b1;
   assign w_idx_next  = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot      <= '0;
         r_idx       <= '0;
         frame_start <= 1'b0;
      end else begin
         r_slot      <= w_slot_next;
         if (w_slot_wrap)
            r_idx <= w_idx_next;
         frame_start <= w_slot_wrap && (w_idx_next == '0);
      end
   end

   // dout only moves at the end of a high phase, so it never changes while sclk is high
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_bit   <= '0;
         r_word  <= '0;
         sclk    <= 1'b0;
         rclk    <= 1'b0;
         dout    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_slot == '0 && en)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_word  <= w_word[14:0];
               r_bit   <= 4'd15;
               dout    <= w_word[15];
               r_phase <= CW'(HALF - 1);
               r_state <= S_BIT_LO;
            end
            S_BIT_LO: begin
               if (r_phase == '0) begin
                  sclk    <= 1'b1;
                  r_phase <= CW'(DIV - HALF - 1);
                  r_state <= S_BIT_HI;
               end else begin
                  r_phase <= r_phase - 1'b1;
               end
            end
            S_BIT_HI: begin
               if (r_phase == '0) begin
                  sclk    <= 1'b0;
                  r_phase <= CW'(HALF - 1);
                  if (r_bit == '0) begin
                     rclk    <= 1'b1;
                     r_state <= S_LATCH;
                  end else begin
                     r_bit   <= r_bit - 1'b1;
                     dout    <= r_word[14];
                     r_word  <= {r_word[13:0], 1'b0};
                     r_state <= S_BIT_LO;
                  end
               end else begin
                  r_phase <= r_phase - 1'b1;
               end
            end
            S_LATCH: begin
               if (r_phase == '0) begin
                  rclk    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_phase <= r_phase - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Display stays lit until a finished latch (or an idle cycle) observes en low
   always_comb begin
      w_on_next = r_on;
      if (r_state == S_IDLE && !en)
         w_on_next = 1'b0;
      else if (r_state == S_IDLE && r_slot == '0)
         w_on_next = 1'b1;
      else if (r_state == S_LATCH && r_phase == '0 && !en)
         w_on_next = 1'b0;
   end

`ifdef SEVENSEG_BRIGHTNESS_EN
   logic [3:0]    r_bright;
   logic [3:0]    w_bright_next;
   logic [SW:0]   w_thr;

   always_comb begin
      w_bright_next = (r_state == S_LOAD) ? bright : r_bright;
      w_thr         = (SW+1)'((32'(w_bright_next) + 32'd1) * 32'(SLOT / 16));
   end
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_on <= 1'b0;
         oe_n <= 1'b1;
`ifdef SEVENSEG_BRIGHTNESS_EN
         r_bright <= 4'hF;
`endif
      end else begin
         r_on <= w_on_next;
`ifdef SEVENSEG_BRIGHTNESS_EN
         r_bright <= w_bright_next;
         oe_n     <= !(w_on_next && (w_bright_next == 4'hF || {1'b0, w_slot_next} < w_thr));
`else
         oe_n     <= !w_on_next;
`endif
      end
   end
endmodule
